// File: rtl/axil_bus_arbiter_2to1_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    M_ISSUE,
    M_WAIT,
    S_RESP
  } state_t;

  typedef enum logic {
    WR,
    RD
  } kind_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_bus_arbiter_2to1_if.sv
// AXI4-Lite bundle; master drives address/data/resp-ready, slave drives the rest.
interface axi4_lite_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_bus_arbiter_2to1_rr_grant2.sv
// Two-way round-robin pick: under contention the port that did not win last time wins.
module axil_rr_grant2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       valid_o
);
  always_comb begin
    valid_o = |req_i;
    if (&req_i) begin
      gnt_o = ~last_i;
    end else begin
      gnt_o = req_i[1];
    end
  end
endmodule

// File: rtl/axil_bus_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter, one transaction in flight, with a
// response watchdog that answers SLVERR when the downstream slave hangs.
module axil_bus_arbiter_2to1
  import axil_arb_pkg::*;
#(
  parameter int unsigned   AW             = 32,
  parameter int unsigned   DW             = 32,
  parameter int unsigned   TIMEOUT_CYCLES = 1024,
  parameter logic [DW-1:0] TIMEOUT_RDATA  = DW'(32'hDEAD_BEEF)
) (
  input  logic       aclk,
  input  logic       aresetn,
  axi4_lite_if.slave  s0,
  axi4_lite_if.slave  s1,
  axi4_lite_if.master m,
  output logic       busy,
  output logic       grant,
  output logic       timeout
);
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic            grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            aw_pend_q, aw_pend_d;
  logic            w_pend_q, w_pend_d;
  logic            ar_pend_q, ar_pend_d;
  logic [1:0]      resp_q, resp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            init_q;

  logic [1:0]    wr_req, rd_req;
  logic          pick, pick_valid, pick_wr, accept, wd_fire;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [SW-1:0] sel_wstrb;
  logic          unused_prot;

  assign unused_prot = ^{s0.awprot, s0.arprot, s1.awprot, s1.arprot};

  assign wr_req = {s1.awvalid & s1.wvalid, s0.awvalid & s0.wvalid};
  assign rd_req = {s1.arvalid, s0.arvalid};

  axil_rr_grant2 u_rr (
    .req_i   (wr_req | rd_req),
    .last_i  (grant_q),
    .gnt_o   (pick),
    .valid_o (pick_valid)
  );

  // init_q keeps every ready low while reset is held and for the first edge after.
  assign pick_wr = wr_req[pick];
  assign accept  = (state_q == IDLE) && init_q && pick_valid;
  assign wd_fire = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    if (pick) begin
      sel_addr  = pick_wr ? s1.awaddr : s1.araddr;
      sel_wdata = s1.wdata;
      sel_wstrb = s1.wstrb;
    end else begin
      sel_addr  = pick_wr ? s0.awaddr : s0.araddr;
      sel_wdata = s0.wdata;
      sel_wstrb = s0.wstrb;
    end
  end

  assign m.awaddr  = addr_q;
  assign m.araddr  = addr_q;
  assign m.awprot  = 3'b000;
  assign m.arprot  = 3'b000;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.awvalid = aw_pend_q;
  assign m.wvalid  = w_pend_q;
  assign m.arvalid = ar_pend_q;

  assign s0.bresp = resp_q;
  assign s0.rresp = resp_q;
  assign s0.rdata = rdata_q;
  assign s1.bresp = resp_q;
  assign s1.rresp = resp_q;
  assign s1.rdata = rdata_q;

  assign busy    = (state_q != IDLE);
  assign grant   = grant_q;
  assign timeout = timeout_q;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    ar_pend_d = ar_pend_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    cnt_d     = '0;
    timeout_d = 1'b0;

    s0.awready = 1'b0;
    s0.wready  = 1'b0;
    s0.arready = 1'b0;
    s0.bvalid  = 1'b0;
    s0.rvalid  = 1'b0;
    s1.awready = 1'b0;
    s1.wready  = 1'b0;
    s1.arready = 1'b0;
    s1.bvalid  = 1'b0;
    s1.rvalid  = 1'b0;
    m.bready   = 1'b0;
    m.rready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Drain any stray response left over from a timed-out transaction.
        m.bready = init_q;
        m.rready = init_q;
        if (accept) begin
          if (pick) begin
            s1.awready = pick_wr;
            s1.wready  = pick_wr;
            s1.arready = ~pick_wr;
          end else begin
            s0.awready = pick_wr;
            s0.wready  = pick_wr;
            s0.arready = ~pick_wr;
          end
          grant_d   = pick;
          kind_d    = pick_wr ? WR : RD;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          wstrb_d   = sel_wstrb;
          aw_pend_d = pick_wr;
          w_pend_d  = pick_wr;
          ar_pend_d = ~pick_wr;
          state_d   = M_ISSUE;
        end
      end
      M_ISSUE: begin
        if (aw_pend_q && m.awready) aw_pend_d = 1'b0;
        if (w_pend_q && m.wready)   w_pend_d  = 1'b0;
        if (ar_pend_q && m.arready) ar_pend_d = 1'b0;
        if (!aw_pend_d && !w_pend_d && !ar_pend_d) state_d = M_WAIT;
      end
      M_WAIT: begin
        cnt_d = cnt_q + CntW'(1);
        if (kind_q == WR) begin
          m.bready = 1'b1;
          if (m.bvalid) begin
            resp_d  = m.bresp;
            state_d = S_RESP;
          end
        end else begin
          m.rready = 1'b1;
          if (m.rvalid) begin
            resp_d  = m.rresp;
            rdata_d = m.rdata;
            state_d = S_RESP;
          end
        end
        // A real response arriving on the firing cycle takes precedence.
        if (state_d == M_WAIT && wd_fire) begin
          resp_d    = RESP_SLVERR;
          rdata_d   = TIMEOUT_RDATA;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (kind_q == WR) begin
          if (grant_q) s1.bvalid = 1'b1;
          else         s0.bvalid = 1'b1;
          if (grant_q ? s1.bready : s0.bready) state_d = IDLE;
        end else begin
          if (grant_q) s1.rvalid = 1'b1;
          else         s0.rvalid = 1'b1;
          if (grant_q ? s1.rready : s0.rready) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      kind_q    <= WR;
      grant_q   <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ar_pend_q <= ar_pend_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      init_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axil_bus_arbiter_2to1.sv
// Directed bench for axil_bus_arbiter_2to1: bench-side masters on s0/s1 and a
// scripted slave on m, with hand-computed expectations.
module tb_axil_bus_arbiter_2to1;
  import axil_arb_pkg::*;

  localparam int unsigned TO = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic busy, grant, timeout;
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  axi4_lite_if #(.AW(32), .DW(32)) s0_if ();
  axi4_lite_if #(.AW(32), .DW(32)) s1_if ();
  axi4_lite_if #(.AW(32), .DW(32)) m_if ();

  axil_bus_arbiter_2to1 #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_RDATA  (32'hDEAD_BEEF)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s0      (s0_if),
    .s1      (s1_if),
    .m       (m_if),
    .busy    (busy),
    .grant   (grant),
    .timeout (timeout)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic s_wr(input int p, input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st);
    if (p == 0) begin
      s0_if.awvalid = v; s0_if.wvalid = v; s0_if.awaddr = a; s0_if.wdata = d; s0_if.wstrb = st;
    end else begin
      s1_if.awvalid = v; s1_if.wvalid = v; s1_if.awaddr = a; s1_if.wdata = d; s1_if.wstrb = st;
    end
  endtask

  task automatic s_rd(input int p, input logic v, input logic [31:0] a);
    if (p == 0) begin
      s0_if.arvalid = v; s0_if.araddr = a;
    end else begin
      s1_if.arvalid = v; s1_if.araddr = a;
    end
  endtask

  task automatic clear_all();
    s_wr(0, 1'b0, '0, '0, '0);
    s_wr(1, 1'b0, '0, '0, '0);
    s_rd(0, 1'b0, '0);
    s_rd(1, 1'b0, '0);
    s0_if.awprot = '0; s0_if.arprot = '0; s0_if.bready = 1'b0; s0_if.rready = 1'b0;
    s1_if.awprot = '0; s1_if.arprot = '0; s1_if.bready = 1'b0; s1_if.rready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
    m_if.bvalid = 1'b0; m_if.bresp = '0; m_if.rvalid = 1'b0; m_if.rresp = '0; m_if.rdata = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  // Downstream slave: accept the write, wait dly cycles, answer with resp.
  task automatic m_serve_wr(input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es,
                            input int dly, input logic [1:0] resp);
    int n = 0;
    while (!m_if.awvalid && n < 32) begin tick(); n++; end
    check("m_awvalid", m_if.awvalid, 1'b1);
    check("m_wvalid", m_if.wvalid, 1'b1);
    check("m_awaddr", m_if.awaddr, ea);
    check("m_wdata", m_if.wdata, ed);
    check("m_wstrb", m_if.wstrb, es);
    check("m_awprot", m_if.awprot, 3'b000);
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    tick();
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    repeat (dly) tick();
    m_if.bvalid = 1'b1; m_if.bresp = resp;
    n = 0;
    while (!m_if.bready && n < 32) begin tick(); n++; end
    check("m_bready", m_if.bready, 1'b1);
    tick();
    m_if.bvalid = 1'b0;
  endtask

  task automatic m_serve_rd(input logic [31:0] ea, input int dly, input logic [31:0] rd,
                            input logic [1:0] resp);
    int n = 0;
    while (!m_if.arvalid && n < 32) begin tick(); n++; end
    check("m_arvalid", m_if.arvalid, 1'b1);
    check("m_araddr", m_if.araddr, ea);
    check("m_arprot", m_if.arprot, 3'b000);
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    repeat (dly) tick();
    m_if.rvalid = 1'b1; m_if.rdata = rd; m_if.rresp = resp;
    n = 0;
    while (!m_if.rready && n < 32) begin tick(); n++; end
    check("m_rready", m_if.rready, 1'b1);
    tick();
    m_if.rvalid = 1'b0;
  endtask

  task automatic s_collect_b(input int p, input logic [1:0] exp_resp);
    int n = 0;
    while (!(p == 0 ? s0_if.bvalid : s1_if.bvalid) && n < 32) begin tick(); n++; end
    check("s_bvalid", p == 0 ? s0_if.bvalid : s1_if.bvalid, 1'b1);
    check("s_bresp", p == 0 ? s0_if.bresp : s1_if.bresp, exp_resp);
    if (p == 0) s0_if.bready = 1'b1; else s1_if.bready = 1'b1;
    tick();
    s0_if.bready = 1'b0; s1_if.bready = 1'b0;
  endtask

  task automatic s_collect_r(input int p, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n = 0;
    while (!(p == 0 ? s0_if.rvalid : s1_if.rvalid) && n < 32) begin tick(); n++; end
    check("s_rvalid", p == 0 ? s0_if.rvalid : s1_if.rvalid, 1'b1);
    check("s_rdata", p == 0 ? s0_if.rdata : s1_if.rdata, exp_data);
    check("s_rresp", p == 0 ? s0_if.rresp : s1_if.rresp, exp_resp);
    if (p == 0) s0_if.rready = 1'b1; else s1_if.rready = 1'b1;
    tick();
    s0_if.rready = 1'b0; s1_if.rready = 1'b0;
  endtask

  function automatic logic [31:0] t5_addr(input int p, input int n);
    return 32'h100 + 32'(p) * 32'h80 + 32'(n) * 32'd4;
  endfunction

  function automatic logic [31:0] t5_data(input int p, input int n);
    return 32'hC0DE_0000 | (32'(p) << 8) | 32'(n);
  endfunction

  initial begin
    int p, n, n0, n1, tout;
    clear_all();

    // Reset values
    tick(); tick();
    check("rst_m_awvalid", m_if.awvalid, 1'b0);
    check("rst_m_arvalid", m_if.arvalid, 1'b0);
    check("rst_m_bready", m_if.bready, 1'b0);
    check("rst_m_rready", m_if.rready, 1'b0);
    check("rst_s0_bvalid", s0_if.bvalid, 1'b0);
    check("rst_s1_rvalid", s1_if.rvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_grant", grant, 1'b1);
    aresetn = 1'b1;
    tick();
    check("idle_m_bready", m_if.bready, 1'b1);

    // 1: s0 single write, OKAY after 3 cycles
    s_wr(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
    #1;
    check("t1_s0_awready", s0_if.awready, 1'b1);
    check("t1_s0_wready", s0_if.wready, 1'b1);
    check("t1_s1_awready", s1_if.awready, 1'b0);
    tick();
    s_wr(0, 1'b0, '0, '0, '0);
    check("t1_grant", grant, 1'b0);
    check("t1_busy", busy, 1'b1);
    check("t1_s0_awready_low", s0_if.awready, 1'b0);
    m_serve_wr(32'h10, 32'hA5A5_0001, 4'hF, 3, RESP_OKAY);
    check("t1_s1_bvalid", s1_if.bvalid, 1'b0);
    s_collect_b(0, RESP_OKAY);
    check("t1_busy_end", busy, 1'b0);
    check("t1_s0_bvalid_end", s0_if.bvalid, 1'b0);

    // 2: simultaneous reads after reset, s0 first
    do_reset();
    s_rd(0, 1'b1, 32'h20);
    s_rd(1, 1'b1, 32'h24);
    #1;
    check("t2_s0_arready", s0_if.arready, 1'b1);
    check("t2_s1_arready", s1_if.arready, 1'b0);
    tick();
    s_rd(0, 1'b0, '0);
    check("t2_grant0", grant, 1'b0);
    m_serve_rd(32'h20, 1, 32'h1111_0000, RESP_OKAY);
    check("t2_s1_rvalid", s1_if.rvalid, 1'b0);
    s_collect_r(0, 32'h1111_0000, RESP_OKAY);
    check("t2_s1_arready2", s1_if.arready, 1'b1);
    tick();
    s_rd(1, 1'b0, '0);
    check("t2_grant1", grant, 1'b1);
    m_serve_rd(32'h24, 0, 32'h2222_0000, RESP_OKAY);
    s_collect_r(1, 32'h2222_0000, RESP_OKAY);

    // 3: s1 write and read together, write first
    s_wr(1, 1'b1, 32'h30, 32'h3333_0003, 4'h3);
    s_rd(1, 1'b1, 32'h34);
    #1;
    check("t3_s1_awready", s1_if.awready, 1'b1);
    check("t3_s1_arready", s1_if.arready, 1'b0);
    tick();
    s_wr(1, 1'b0, '0, '0, '0);
    check("t3_m_arvalid", m_if.arvalid, 1'b0);
    m_serve_wr(32'h30, 32'h3333_0003, 4'h3, 0, RESP_OKAY);
    s_collect_b(1, RESP_OKAY);
    check("t3_s1_arready2", s1_if.arready, 1'b1);
    tick();
    s_rd(1, 1'b0, '0);
    m_serve_rd(32'h34, 0, 32'h4444_0004, RESP_OKAY);
    s_collect_r(1, 32'h4444_0004, RESP_OKAY);

    // 4: read timeout, then a late response absorbed in IDLE
    s_rd(0, 1'b1, 32'h40);
    #1;
    check("t4_s0_arready", s0_if.arready, 1'b1);
    tick();
    s_rd(0, 1'b0, '0);
    check("t4_m_araddr", m_if.araddr, 32'h40);
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    check("t4_m_rready", m_if.rready, 1'b1);
    tout = 0;
    for (int i = 0; i < 16; i++) begin
      check("t4_no_early_rvalid", s0_if.rvalid, 1'b0);
      tout += int'(timeout);
      tick();
    end
    tout += int'(timeout);
    check("t4_rvalid", s0_if.rvalid, 1'b1);
    check("t4_rresp", s0_if.rresp, RESP_SLVERR);
    check("t4_rdata", s0_if.rdata, 32'hDEAD_BEEF);
    s0_if.rready = 1'b1;
    tick();
    s0_if.rready = 1'b0;
    tout += int'(timeout);
    check("t4_timeout_pulses", tout, 1);
    m_if.rvalid = 1'b1; m_if.rdata = 32'h5555_5555;
    #1;
    check("t4_late_rready", m_if.rready, 1'b1);
    tick();
    m_if.rvalid = 1'b0;
    check("t4_late_s0_rvalid", s0_if.rvalid, 1'b0);
    check("t4_late_s1_rvalid", s1_if.rvalid, 1'b0);
    check("t4_late_busy", busy, 1'b0);

    // 5: both ports stream 8 writes each, strict alternation
    do_reset();
    n0 = 0; n1 = 0;
    s_wr(0, 1'b1, t5_addr(0, 0), t5_data(0, 0), 4'hF);
    s_wr(1, 1'b1, t5_addr(1, 0), t5_data(1, 0), 4'hF);
    for (int k = 0; k < 16; k++) begin
      p = k % 2;
      n = (p == 0) ? n0 : n1;
      #1;
      check("t5_s0_awready", s0_if.awready, p == 0);
      check("t5_s1_awready", s1_if.awready, p == 1);
      tick();
      check("t5_grant", grant, p[0]);
      if (p == 0) begin
        n0++;
        s_wr(0, n0 < 8, t5_addr(0, n0), t5_data(0, n0), 4'hF);
      end else begin
        n1++;
        s_wr(1, n1 < 8, t5_addr(1, n1), t5_data(1, n1), 4'hF);
      end
      m_serve_wr(t5_addr(p, n), t5_data(p, n), 4'hF, k % 3, RESP_OKAY);
      s_collect_b(p, RESP_OKAY);
    end

    // 6: reset in M_WAIT, then a normal read
    s_wr(0, 1'b1, 32'h60, 32'h6060_6060, 4'hF);
    #1;
    tick();
    s_wr(0, 1'b0, '0, '0, '0);
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    tick();
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    check("t6_busy_wait", busy, 1'b1);
    aresetn = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_grant", grant, 1'b1);
    check("t6_m_awvalid", m_if.awvalid, 1'b0);
    check("t6_m_bready", m_if.bready, 1'b0);
    check("t6_s0_bvalid", s0_if.bvalid, 1'b0);
    check("t6_timeout", timeout, 1'b0);
    tick();
    aresetn = 1'b1;
    tick();
    s_rd(0, 1'b1, 32'h64);
    #1;
    check("t6_s0_arready", s0_if.arready, 1'b1);
    tick();
    s_rd(0, 1'b0, '0);
    m_serve_rd(32'h64, 2, 32'h6666_0006, RESP_OKAY);
    s_collect_r(0, 32'h6666_0006, RESP_OKAY);
    check("t6_busy_end", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
